led_counter_pwm_ar: RTL and testbench

//  User-panel block: four raw pushbuttons drive a signed saturating up/down counter and a saturating brightness level.

---
 rtl/led_counter_pwm_ar.sv | 256 +++++++++++++++++++++++++
 tb/tb_led_counter_pwm_ar.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/led_counter_pwm_ar.sv
// led_counter_pwm_ar
//   User-panel block. Four raw pushbuttons drive a signed saturating up/down
//   counter and a saturating brightness level. The counter is shown on WIDTH
//   LEDs, dimmed by a PWM with LEVELS duty steps. Each button has its own
//   synchroniser, debouncer and press/hold-to-repeat event generator.
//
// Ports
//   clk      in   1      system clock
//   reset_n  in   1      synchronous, active-low reset
//   btn      in   4      raw buttons, active-high: [0] dec, [1] inc, [2] dim, [3] brighten
//   led      out  WIDTH  count gated by the PWM phase
//   count    out  WIDTH  current signed (two's complement) counter value
//   level    out  4      current brightness level, zero-extended
//   pwm_on   out  1      registered PWM phase
//
// Latency from a clean raw press to a count change:
//   2 (synchroniser) + DEBOUNCE_CYCLES + 1 (event register) + 1 (counter register).
module led_counter_pwm_ar #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned LEVELS          = 6,
  parameter int unsigned RESET_LEVEL     = 5,
  parameter int unsigned PWM_PERIOD      = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       btn,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       level,
  output logic             pwm_on
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("led_counter_pwm_ar: WIDTH must be in 2..16");
  end
  if (LEVELS < 2 || LEVELS > 16) begin : g_bad_levels
    $error("led_counter_pwm_ar: LEVELS must be in 2..16");
  end
  if (RESET_LEVEL >= LEVELS) begin : g_bad_reset_level
    $error("led_counter_pwm_ar: RESET_LEVEL must be below LEVELS");
  end
  if (PWM_PERIOD < 1 || (LEVELS > 1 && (PWM_PERIOD % (LEVELS - 1)) != 0)) begin : g_bad_pwm
    $error("led_counter_pwm_ar: PWM_PERIOD must be >= 1 and divisible by LEVELS-1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("led_counter_pwm_ar: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("led_counter_pwm_ar: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned DbW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrMax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
  localparam int unsigned TmrW    = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam int unsigned PcW     = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned PwmStep = (LEVELS > 1) ? PWM_PERIOD / (LEVELS - 1) : 1;

  localparam logic [WIDTH-1:0] CntMax   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] CntMin   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       LevelMax = 4'(LEVELS - 1);
  localparam logic [3:0]       LevelRst = 4'(RESET_LEVEL);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRpt
  } btn_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for all buttons
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // One registered, single-cycle event strobe per button.
  logic [3:0] btn_event;

  // ---------------------------------------------------------------------------
  // Per-button debounce and press/repeat event FSM
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic            deb_q, deb_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    btn_state_e      state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            ev_q, ev_d;

    // Debounce: the accepted value only follows the synced input after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; agreement clears the run.
    always_comb begin
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (sync2_q[i] != deb_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = sync2_q[i];
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
    end

    // Event FSM. IDLE is only re-entered while the debounced level is low, so
    // seeing it high in IDLE is exactly a debounced rising edge.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      ev_d    = 1'b0;
      if (!deb_q) begin
        state_d = StIdle;
        tmr_d   = '0;
      end else begin
        case (state_q)
          StIdle: begin
            ev_d    = 1'b1;
            state_d = StHold;
            tmr_d   = '0;
          end
          StHold: begin
            if (tmr_q == TmrW'(REPEAT_DELAY - 1)) begin
              ev_d    = 1'b1;
              state_d = StRpt;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TmrW'(1);
            end
          end
          StRpt: begin
            if (tmr_q == TmrW'(REPEAT_PERIOD - 1)) begin
              ev_d  = 1'b1;
              tmr_d = '0;
            end else begin
              tmr_d = tmr_q + TmrW'(1);
            end
          end
          default: begin
            state_d = StIdle;
            tmr_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        deb_q    <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= StIdle;
        tmr_q    <= '0;
        ev_q     <= 1'b0;
      end else begin
        deb_q    <= deb_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        tmr_q    <= tmr_d;
        ev_q     <= ev_d;
      end
    end

    assign btn_event[i] = ev_q;
  end

  // ---------------------------------------------------------------------------
  // Saturating counter and brightness level
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       level_q, level_d;

  // Opposing events in the same cycle cancel.
  logic ev_dec, ev_inc, ev_dim, ev_bri;
  assign ev_dec = btn_event[0] & ~btn_event[1];
  assign ev_inc = btn_event[1] & ~btn_event[0];
  assign ev_dim = btn_event[2] & ~btn_event[3];
  assign ev_bri = btn_event[3] & ~btn_event[2];

  always_comb begin
    count_d = count_q;
    if (ev_dec && count_q != CntMin) begin
      count_d = count_q - WIDTH'(1);
    end else if (ev_inc && count_q != CntMax) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_comb begin
    level_d = level_q;
    if (ev_dim && level_q != 4'd0) begin
      level_d = level_q - 4'd1;
    end else if (ev_bri && level_q != LevelMax) begin
      level_d = level_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      level_q <= LevelRst;
    end else begin
      count_q <= count_d;
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM: free-running period counter; duty threshold follows the current level
  // without restarting the period.
  // ---------------------------------------------------------------------------
  logic [PcW-1:0] pc_q, pc_d;
  logic [31:0]    pwm_thr;
  logic           pwm_q, pwm_d;

  assign pwm_thr = 32'(level_q) * PwmStep;

  always_comb begin
    pc_d  = (pc_q == PcW'(PWM_PERIOD - 1)) ? '0 : pc_q + PcW'(1);
    pwm_d = (32'(pc_q) < pwm_thr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      pwm_q <= pwm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count  = count_q;
  assign level  = level_q;
  assign pwm_on = pwm_q;
  assign led    = count_q & {WIDTH{pwm_q}};

endmodule

// File: tb/tb_led_counter_pwm_ar.sv
// Directed bench for led_counter_pwm_ar with small timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_led_counter_pwm_ar;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       btn;
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] count;
  logic [3:0]       level;
  logic             pwm_on;

  int checks   = 0;
  int failures = 0;

  led_counter_pwm_ar #(
    .WIDTH          (4),
    .LEVELS         (6),
    .RESET_LEVEL    (5),
    .PWM_PERIOD     (10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (btn),
    .led    (led),
    .count  (count),
    .level  (level),
    .pwm_on (pwm_on)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Clean press: one event only (released long before the repeat delay).
  task automatic press(input logic [3:0] mask);
    btn = mask;
    ticks(6);
    btn = 4'b0000;
    ticks(20);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic count_high(input int n, output int hi_pwm, output int hi_led);
    hi_pwm = 0;
    hi_led = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (pwm_on) hi_pwm++;
      if (led != '0) hi_led++;
    end
  endtask

  initial begin
    int hp, hl;
    reset_n = 1'b0;
    btn     = 4'b0000;
    ticks(2);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_level", 32'(level), 32'd5);
    check_val("rst_led", 32'(led), 32'd0);
    check_val("rst_pwm", 32'(pwm_on), 32'd0);
    reset_n = 1'b1;

    // 1: clean press of inc; count changes on the 8th edge after press
    btn = 4'b0010;
    ticks(6);
    btn = 4'b0000;
    tick();
    check_val("t1_count_at7", 32'(count), 32'd0);
    tick();
    check_val("t1_count_at8", 32'(count), 32'd1);
    check_val("t1_pwm", 32'(pwm_on), 32'd1);
    check_val("t1_led", 32'(led), 32'd1);
    ticks(20);
    check_val("t1_count_once", 32'(count), 32'd1);
    count_high(10, hp, hl);
    check_val("t1_pwm_full", 32'(hp), 32'd10);

    // 2: bouncing input every 2 cycles is rejected
    repeat (10) begin
      btn = 4'b0010;
      ticks(2);
      btn = 4'b0000;
      ticks(2);
    end
    ticks(10);
    check_val("t2_bounce", 32'(count), 32'd1);

    // 3: hold inc; events at 0,20,28,36,44,52 then saturate at 7
    pulse_reset();
    check_val("t3_rst_count", 32'(count), 32'd0);
    btn = 4'b0010;
    ticks(8);
    check_val("t3_first", 32'(count), 32'd1);
    ticks(19);
    check_val("t3_before_rpt", 32'(count), 32'd1);
    tick();
    check_val("t3_first_rpt", 32'(count), 32'd2);
    ticks(32);
    check_val("t3_six", 32'(count), 32'd6);
    ticks(8);
    check_val("t3_max", 32'(count), 32'd7);
    ticks(32);
    check_val("t3_sat", 32'(count), 32'd7);
    btn = 4'b0000;
    ticks(20);
    check_val("t3_no_wrap", 32'(count), 32'd7);

    // 4: negative saturation and cancelling dec+inc
    pulse_reset();
    repeat (7) press(4'b0001);
    check_val("t4_m7", 32'(count), 32'h9);
    press(4'b0001);
    check_val("t4_m8", 32'(count), 32'h8);
    press(4'b0001);
    check_val("t4_m8_sat", 32'(count), 32'h8);
    press(4'b0011);
    check_val("t4_both", 32'(count), 32'h8);
    check_val("t4_level", 32'(level), 32'd5);

    // 5: dimming to level 2 (4/10 duty) then to 0 (dark)
    repeat (3) press(4'b0100);
    check_val("t5_level2", 32'(level), 32'd2);
    count_high(10, hp, hl);
    check_val("t5_pwm_duty", 32'(hp), 32'd4);
    check_val("t5_led_duty", 32'(hl), 32'd4);
    repeat (3) press(4'b0100);
    check_val("t5_level0", 32'(level), 32'd0);
    press(4'b0100);
    check_val("t5_level_sat", 32'(level), 32'd0);
    press(4'b1100);
    check_val("t5_dim_bri", 32'(level), 32'd0);
    count_high(20, hp, hl);
    check_val("t5_pwm_off", 32'(hp), 32'd0);
    check_val("t5_led_off", 32'(hl), 32'd0);

    // 6: hold brighten (+inc to make events visible), reset mid-repeat
    btn = 4'b1010;
    ticks(40);
    check_val("t6_pre_level", 32'(level), 32'd3);
    check_val("t6_pre_count", 32'(count), 32'hB);
    pulse_reset();
    check_val("t6_rst_count", 32'(count), 32'd0);
    check_val("t6_rst_level", 32'(level), 32'd5);
    check_val("t6_rst_led", 32'(led), 32'd0);
    ticks(7);
    check_val("t6_wait_count", 32'(count), 32'd0);
    check_val("t6_pwm", 32'(pwm_on), 32'd1);
    tick();
    check_val("t6_fresh", 32'(count), 32'd1);
    check_val("t6_level_sat", 32'(level), 32'd5);
    ticks(19);
    check_val("t6_one_event", 32'(count), 32'd1);
    tick();
    check_val("t6_rpt", 32'(count), 32'd2);
    btn = 4'b0000;
    ticks(20);
    check_val("t6_level_end", 32'(level), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
